// File: rtl/ring_johnson_counter_pkg.sv
// Shared encodings for the ring/Johnson shift counter family: mode and direction
// selects, plus the seed value loaded on reset and on self-correction.
package ring_johnson_counter_pkg;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Seed is 0...01; legal in both ring and Johnson sequences.
    localparam int unsigned SEED_VALUE = 1;

endpackage

// File: rtl/ring_johnson_counter_if.sv
// Control/status bundle for ring_johnson_counter; master drives controls,
// slave (the counter) returns state, index and status pulses.
interface ring_johnson_counter_if #(
    parameter int WIDTH = 4
);
    localparam int IDXW = $clog2(2 * WIDTH);

    logic             en;
    logic             mode;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic [IDXW-1:0]  idx;
    logic             wrap;
    logic             illegal;
    logic             err;

    modport master (
        output en, mode, dir, load, load_val,
        input  q, idx, wrap, illegal, err
    );

    modport slave (
        input  en, mode, dir, load, load_val,
        output q, idx, wrap, illegal, err
    );

endinterface

// File: rtl/ring_johnson_counter_decode.sv
// Combinational legality check and position decode for a ring (one-hot) or
// Johnson (twisted-ring) state word; illegal states decode to index 0.
module ring_state_decode
    import ring_johnson_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]               q_i,
    input  logic                           mode_i,
    output logic                           illegal_o,
    output logic [$clog2(2*WIDTH)-1:0]     idx_o
);
    localparam int IDXW = $clog2(2 * WIDTH);

    logic [WIDTH-1:0] q_inv;
    logic             low_run_ok;
    logic             high_run_ok;
    logic             legal;
    int               pop_cnt;
    int               one_pos;
    int               idx_int;

    assign q_inv = ~q_i;

    // x & (x+1) == 0 exactly when x is a run of ones anchored at bit 0 (incl. 0).
    assign low_run_ok  = ((q_i & (q_i + WIDTH'(1))) == '0);
    assign high_run_ok = ((q_inv & (q_inv + WIDTH'(1))) == '0);

    always_comb begin
        pop_cnt = 0;
        one_pos = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (q_i[i]) begin
                pop_cnt = pop_cnt + 1;
                one_pos = i;
            end
        end
    end

    always_comb begin
        legal   = 1'b0;
        idx_int = 0;
        if (mode_i == MODE_RING) begin
            legal   = (pop_cnt == 1);
            idx_int = one_pos;
        end else begin
            legal   = low_run_ok || high_run_ok;
            idx_int = q_i[WIDTH-1] ? (2 * WIDTH - pop_cnt) : pop_cnt;
        end
    end

    assign illegal_o = !legal;
    assign idx_o     = legal ? IDXW'(idx_int) : '0;

endmodule

// File: rtl/ring_johnson_counter.sv
// Parametrised ring/Johnson shift counter with up/down, load, wrap pulse and
// self-correction of illegal states on the next enabled edge.
module ring_johnson_counter
    import ring_johnson_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    ring_johnson_counter_if.slave   bus
);
    localparam int IDXW = $clog2(2 * WIDTH);
    localparam logic [WIDTH-1:0] SEED     = WIDTH'(SEED_VALUE);
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic             illegal;
    logic [IDXW-1:0]  idx;

    ring_state_decode #(.WIDTH(WIDTH)) u_decode (
        .q_i       (q_q),
        .mode_i    (bus.mode),
        .illegal_o (illegal),
        .idx_o     (idx)
    );

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (bus.load) begin
            q_d = bus.load_val;
        end else if (bus.en) begin
            if (illegal) begin
                q_d   = SEED;
                err_d = 1'b1;
            end else begin
                if (bus.dir == DIR_UP) begin
                    q_d = {q_q[WIDTH-2:0], (bus.mode == MODE_JOHNSON) ^ q_q[WIDTH-1]};
                end else begin
                    q_d = {(bus.mode == MODE_JOHNSON) ^ q_q[0], q_q[WIDTH-1:1]};
                end
                // Both modes wrap upward out of 10..0; downward wrap starts at 0..01 or 0..0.
                if (bus.dir == DIR_UP) begin
                    wrap_d = (q_q == MSB_ONLY);
                end else if (bus.mode == MODE_RING) begin
                    wrap_d = (q_q == SEED);
                end else begin
                    wrap_d = (q_q == '0);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q    <= SEED;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign bus.q       = q_q;
    assign bus.wrap    = wrap_q;
    assign bus.err     = err_q;
    assign bus.illegal = illegal;
    assign bus.idx     = idx;

endmodule

// File: tb/tb_ring_johnson_counter.sv
// Directed-vector bench for ring_johnson_counter at WIDTH=4 plus a WIDTH=8
// Johnson full-period run.
module tb_ring_johnson_counter;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ring_johnson_counter_if #(.WIDTH(4)) bus4 ();
    ring_johnson_counter_if #(.WIDTH(8)) bus8 ();

    ring_johnson_counter #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
    ring_johnson_counter #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

    typedef struct {
        logic       ld;
        logic       en;
        logic       mode;
        logic       dir;
        logic [3:0] lv;
        logic [3:0] q;
        logic       wrap;
        logic       err;
        logic       ill;
        logic [2:0] idx;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic ld, logic en, logic mode, logic dir, logic [3:0] lv,
                                logic [3:0] q, logic wrap, logic err, logic ill, logic [2:0] idx);
        vec_t v;
        v.ld = ld; v.en = en; v.mode = mode; v.dir = dir; v.lv = lv;
        v.q = q; v.wrap = wrap; v.err = err; v.ill = ill; v.idx = idx;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic ld, input logic en, input logic mode, input logic dir,
                          input logic [3:0] lv);
        bus4.load = ld; bus4.en = en; bus4.mode = mode; bus4.dir = dir; bus4.load_val = lv;
    endtask

    function automatic logic [7:0] johnson8(input int k);
        logic [7:0] ones;
        if (k <= 8) begin
            ones = (k == 8) ? 8'hFF : 8'((1 << k) - 1);
            return ones;
        end
        ones = 8'((1 << (k - 8)) - 1);
        return ~ones;
    endfunction

    initial begin
        int k;
        int wraps;

        reset = 1'b0;
        drive4(0, 0, 0, 0, 4'b0000);
        bus8.load = 0; bus8.en = 0; bus8.mode = 0; bus8.dir = 0; bus8.load_val = '0;

        // Reset state
        #12;
        check("rst_q", 32'(bus4.q), 32'h1);
        check("rst_wrap", 32'(bus4.wrap), 32'h0);
        check("rst_err", 32'(bus4.err), 32'h0);
        check("rst_idx_ring", 32'(bus4.idx), 32'h0);
        check("rst_q8", 32'(bus8.q), 32'h01);
        bus4.mode = 1'b1;
        #1;
        check("rst_idx_johnson", 32'(bus4.idx), 32'h1);
        bus4.mode = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        //          ld en m d lv        q        w  e  i  idx
        vecs.push_back(mk(0, 1, 0, 0, 4'b0000, 4'b0010, 0, 0, 0, 3'd1));
        vecs.push_back(mk(0, 1, 0, 0, 4'b0000, 4'b0100, 0, 0, 0, 3'd2));
        vecs.push_back(mk(0, 1, 0, 0, 4'b0000, 4'b1000, 0, 0, 0, 3'd3));
        vecs.push_back(mk(0, 1, 0, 0, 4'b0000, 4'b0001, 1, 0, 0, 3'd0));
        vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 4'b0011, 0, 0, 0, 3'd2));
        vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 4'b0111, 0, 0, 0, 3'd3));
        vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 4'b1111, 0, 0, 0, 3'd4));
        vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 4'b1110, 0, 0, 0, 3'd5));
        vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 4'b1100, 0, 0, 0, 3'd6));
        vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 4'b1000, 0, 0, 0, 3'd7));
        vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 4'b0000, 1, 0, 0, 3'd0));
        vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 4'b0001, 0, 0, 0, 3'd1));
        vecs.push_back(mk(0, 1, 0, 1, 4'b0000, 4'b1000, 1, 0, 0, 3'd3));
        vecs.push_back(mk(0, 0, 0, 1, 4'b0000, 4'b1000, 0, 0, 0, 3'd3));
        vecs.push_back(mk(0, 0, 0, 1, 4'b0000, 4'b1000, 0, 0, 0, 3'd3));
        vecs.push_back(mk(0, 0, 0, 1, 4'b0000, 4'b1000, 0, 0, 0, 3'd3));
        vecs.push_back(mk(1, 0, 0, 0, 4'b0110, 4'b0110, 0, 0, 1, 3'd0));
        vecs.push_back(mk(0, 1, 0, 0, 4'b0000, 4'b0001, 0, 1, 0, 3'd0));
        vecs.push_back(mk(0, 1, 0, 0, 4'b0000, 4'b0010, 0, 0, 0, 3'd1));
        vecs.push_back(mk(0, 1, 0, 1, 4'b0000, 4'b0001, 0, 0, 0, 3'd0));
        vecs.push_back(mk(0, 1, 0, 1, 4'b0000, 4'b1000, 1, 0, 0, 3'd3));
        vecs.push_back(mk(1, 1, 0, 0, 4'b0100, 4'b0100, 0, 0, 0, 3'd2));
        vecs.push_back(mk(1, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 3'd0));
        vecs.push_back(mk(0, 1, 1, 1, 4'b0000, 4'b1000, 1, 0, 0, 3'd7));
        vecs.push_back(mk(0, 1, 1, 1, 4'b0000, 4'b1100, 0, 0, 0, 3'd6));
        vecs.push_back(mk(0, 1, 1, 1, 4'b0000, 4'b1110, 0, 0, 0, 3'd5));
        vecs.push_back(mk(1, 0, 1, 0, 4'b0111, 4'b0111, 0, 0, 0, 3'd3));

        foreach (vecs[i]) begin
            drive4(vecs[i].ld, vecs[i].en, vecs[i].mode, vecs[i].dir, vecs[i].lv);
            tick();
            $display("vec %0d: ld=%b en=%b mode=%b dir=%b -> q=%b wrap=%b err=%b ill=%b idx=%0d",
                     i, vecs[i].ld, vecs[i].en, vecs[i].mode, vecs[i].dir,
                     bus4.q, bus4.wrap, bus4.err, bus4.illegal, bus4.idx);
            check($sformatf("vec%0d_q", i), 32'(bus4.q), 32'(vecs[i].q));
            check($sformatf("vec%0d_wrap", i), 32'(bus4.wrap), 32'(vecs[i].wrap));
            check($sformatf("vec%0d_err", i), 32'(bus4.err), 32'(vecs[i].err));
            check($sformatf("vec%0d_ill", i), 32'(bus4.illegal), 32'(vecs[i].ill));
            check($sformatf("vec%0d_idx", i), 32'(bus4.idx), 32'(vecs[i].idx));
        end

        // Johnson 0111 becomes illegal once mode flips to ring; that edge corrects
        drive4(0, 1, 0, 0, 4'b0000);
        #1;
        check("modeflip_ill_pre", 32'(bus4.illegal), 32'h1);
        check("modeflip_idx_pre", 32'(bus4.idx), 32'h0);
        tick();
        $display("modeflip: q=%b err=%b", bus4.q, bus4.err);
        check("modeflip_q", 32'(bus4.q), 32'h1);
        check("modeflip_err", 32'(bus4.err), 32'h1);
        check("modeflip_ill_post", 32'(bus4.illegal), 32'h0);
        drive4(0, 0, 0, 0, 4'b0000);
        tick();
        check("modeflip_err_clr", 32'(bus4.err), 32'h0);

        // Async reset between edges with wrap high
        drive4(0, 1, 0, 1, 4'b0000);
        tick();
        $display("pre-reset: q=%b wrap=%b", bus4.q, bus4.wrap);
        check("prerst_q", 32'(bus4.q), 32'h8);
        check("prerst_wrap", 32'(bus4.wrap), 32'h1);
        drive4(0, 0, 0, 0, 4'b0000);
        #2;
        reset = 1'b0;
        #1;
        $display("async reset: q=%b wrap=%b", bus4.q, bus4.wrap);
        check("arst_q", 32'(bus4.q), 32'h1);
        check("arst_wrap", 32'(bus4.wrap), 32'h0);
        #1;
        reset = 1'b1;
        drive4(0, 1, 0, 0, 4'b0000);
        tick();
        check("postrst_first_step", 32'(bus4.q), 32'h2);
        drive4(0, 0, 0, 0, 4'b0000);

        // WIDTH=8 Johnson full period: 16 steps, one wrap, back at seed
        bus8.mode = 1'b1;
        bus8.dir  = 1'b0;
        bus8.en   = 1'b1;
        k = 1;
        wraps = 0;
        for (int s = 0; s < 16; s++) begin
            tick();
            k = (k + 1) % 16;
            if (bus8.wrap) wraps++;
            $display("w8 step %0d: q=%b idx=%0d wrap=%b", s, bus8.q, bus8.idx, bus8.wrap);
            check($sformatf("w8_q_%0d", s), 32'(bus8.q), 32'(johnson8(k)));
            check($sformatf("w8_idx_%0d", s), 32'(bus8.idx), 32'(k));
            check($sformatf("w8_wrap_%0d", s), 32'(bus8.wrap), 32'(k == 0));
        end
        bus8.en = 1'b0;
        check("w8_wrap_count", 32'(wraps), 32'd1);
        check("w8_final_q", 32'(bus8.q), 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
